// File: rtl/encoded_pkg.sv
// Shared state indices, encodings and code conversion helpers for encoded_param.
// The FSM reasons in state_idx_t; only the state register is encoding-specific.
package encoded_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2,
        LOCK = 2'd3
    } state_idx_t;

    localparam int ENC_BIN    = 0;
    localparam int ENC_GRAY   = 1;
    localparam int ENC_ONEHOT = 2;

    function automatic logic [3:0] encode_state(input state_idx_t idx, input int enc);
        logic [3:0] code;
        case (enc)
            ENC_ONEHOT: code = 4'b0001 << idx;
            ENC_GRAY:   code = {2'b00, idx[1], idx[1] ^ idx[0]};
            default:    code = {2'b00, idx};
        endcase
        return code;
    endfunction

    // Binary and gray cover all four 2-bit codes, so only one-hot can be illegal.
    function automatic state_idx_t decode_state(input logic [3:0] code, input int enc,
                                                output logic illegal);
        state_idx_t idx;
        illegal = 1'b0;
        idx     = INIT;
        case (enc)
            ENC_ONEHOT: begin
                case (code)
                    4'b0001: idx = INIT;
                    4'b0010: idx = WAIT;
                    4'b0100: idx = RUN;
                    4'b1000: idx = LOCK;
                    default: illegal = 1'b1;
                endcase
            end
            ENC_GRAY: idx = state_idx_t'({code[1], code[1] ^ code[0]});
            default:  idx = state_idx_t'(code[1:0]);
        endcase
        return idx;
    endfunction

    function automatic logic [1:0] moore_out(input state_idx_t idx);
        logic [1:0] o;
        case (idx)
            INIT:    o = 2'b01;
            WAIT:    o = 2'b10;
            RUN:     o = 2'b11;
            default: o = 2'b00;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/encoded_param_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       r_count <= '0;
        else if (clr)                     r_count <= '0;
        else if (inc && (r_count != '1))  r_count <= r_count + 1'b1;
    end

    assign count = r_count;

endmodule

// File: rtl/encoded_param.sv
// Run-length lock monitor: locks after RUN_LEN ones, releases after DROP_LEN zeros,
// with selectable state encoding and recovery from illegal one-hot codes.
module encoded_param
    import encoded_pkg::*;
#(
    parameter int ENCODING = 0,
    parameter int RUN_LEN  = 2,
    parameter int DROP_LEN = 1,
    parameter int CNT_W    = 8,
    localparam int SW      = (ENCODING == 2) ? 4 : 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             data_in,
    output logic [1:0]       data_out,
    output logic [SW-1:0]    estados,
    output logic             lock_pulse,
    output logic [CNT_W-1:0] lock_count,
    output logic             err
);

    if (RUN_LEN < 2 || RUN_LEN > 255 || DROP_LEN < 1 || DROP_LEN > 255) begin : g_bad_param
        $fatal(1, "encoded_param: RUN_LEN must be 2..255 and DROP_LEN 1..255");
    end

    logic [SW-1:0] r_state, w_state_nxt;
    logic [7:0]    r_run_cnt, w_run_nxt;
    logic [7:0]    r_drop_cnt, w_drop_nxt;
    logic          r_pulse, w_pulse_nxt;
    logic          r_err, w_err_nxt;
    logic          w_illegal, w_lock_inc;
    logic [3:0]    w_code;
    state_idx_t    w_cur, w_nxt;

    assign w_code = 4'(r_state);

    always_comb w_cur = decode_state(w_code, ENCODING, w_illegal);

    always_comb begin
        w_nxt       = w_cur;
        w_run_nxt   = r_run_cnt;
        w_drop_nxt  = r_drop_cnt;
        w_pulse_nxt = 1'b0;
        w_err_nxt   = r_err;
        w_lock_inc  = 1'b0;
        if (clr) begin
            w_nxt      = INIT;
            w_run_nxt  = '0;
            w_drop_nxt = '0;
        end else if (w_illegal) begin
            w_nxt      = INIT;
            w_run_nxt  = '0;
            w_drop_nxt = '0;
            w_err_nxt  = 1'b1;
        end else if (en) begin
            case (w_cur)
                INIT: w_nxt = WAIT;
                WAIT: begin
                    if (data_in) begin
                        w_nxt     = RUN;
                        w_run_nxt = 8'd1;
                    end
                end
                RUN: begin
                    if (!data_in) begin
                        w_nxt     = WAIT;
                        w_run_nxt = '0;
                    end else if (r_run_cnt == 8'(RUN_LEN - 1)) begin
                        w_nxt       = LOCK;
                        w_run_nxt   = '0;
                        w_drop_nxt  = '0;
                        w_pulse_nxt = 1'b1;
                        w_lock_inc  = 1'b1;
                    end else begin
                        w_run_nxt = r_run_cnt + 8'd1;
                    end
                end
                LOCK: begin
                    if (data_in) begin
                        w_drop_nxt = '0;
                    end else if (r_drop_cnt == 8'(DROP_LEN - 1)) begin
                        w_nxt      = WAIT;
                        w_drop_nxt = '0;
                    end else begin
                        w_drop_nxt = r_drop_cnt + 8'd1;
                    end
                end
                default: w_nxt = INIT;
            endcase
        end
    end

    assign w_state_nxt = SW'(encode_state(w_nxt, ENCODING));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= SW'(encode_state(INIT, ENCODING));
            r_run_cnt  <= '0;
            r_drop_cnt <= '0;
            r_pulse    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_run_cnt  <= w_run_nxt;
            r_drop_cnt <= w_drop_nxt;
            r_pulse    <= w_pulse_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // lock_count survives clr; only reset zeroes it.
    sat_counter #(.W(CNT_W)) u_lock_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .inc   (w_lock_inc),
        .clr   (1'b0),
        .count (lock_count)
    );

    assign data_out   = w_illegal ? 2'b00 : moore_out(w_cur);
    assign estados    = r_state;
    assign lock_pulse = r_pulse & en;
    assign err        = r_err;

endmodule

// File: tb/tb_encoded_param.sv
// Bench for encoded_param: three configurations driven in lockstep, checked every
// cycle against an abstract run-length model, plus literal checkpoints.
module tb_encoded_param;

    logic clk, reset_n, en, clr, data_in;

    logic [1:0] do0, do1, do2;
    logic [1:0] es0, es1;
    logic [3:0] es2;
    logic       lp0, lp1, lp2;
    logic [7:0] lc0, lc1;
    logic [1:0] lc2;
    logic       er0, er1, er2;

    encoded_param #(.ENCODING(0), .RUN_LEN(2), .DROP_LEN(1), .CNT_W(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .data_in(data_in),
        .data_out(do0), .estados(es0), .lock_pulse(lp0), .lock_count(lc0), .err(er0));
    encoded_param #(.ENCODING(1), .RUN_LEN(4), .DROP_LEN(3), .CNT_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .data_in(data_in),
        .data_out(do1), .estados(es1), .lock_pulse(lp1), .lock_count(lc1), .err(er1));
    encoded_param #(.ENCODING(2), .RUN_LEN(2), .DROP_LEN(1), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .data_in(data_in),
        .data_out(do2), .estados(es2), .lock_pulse(lp2), .lock_count(lc2), .err(er2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance configuration
    int P_ENC[3] = '{0, 1, 2};
    int P_RL[3]  = '{2, 4, 2};
    int P_DL[3]  = '{1, 3, 1};
    int P_MAX[3] = '{255, 255, 3};

    // Model state: 0 INIT, 1 WAIT, 2 RUN, 3 LOCK
    int m_st[3], m_run[3], m_drop[3], m_lc[3];
    bit m_pulse[3], m_err[3], m_ill[3], skip[3];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int enc_code(int enc, int st);
        if (enc == 2) return 1 << st;
        if (enc == 1) begin
            case (st)
                0: return 0;
                1: return 1;
                2: return 3;
                default: return 2;
            endcase
        end
        return st;
    endfunction

    function automatic int dout(int st);
        case (st)
            0: return 1;
            1: return 2;
            2: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int act_es(int i);
        if (i == 0) return int'(es0);
        if (i == 1) return int'(es1);
        return int'(es2);
    endfunction
    function automatic int act_do(int i);
        if (i == 0) return int'(do0);
        if (i == 1) return int'(do1);
        return int'(do2);
    endfunction
    function automatic int act_lp(int i);
        if (i == 0) return int'(lp0);
        if (i == 1) return int'(lp1);
        return int'(lp2);
    endfunction
    function automatic int act_lc(int i);
        if (i == 0) return int'(lc0);
        if (i == 1) return int'(lc1);
        return int'(lc2);
    endfunction
    function automatic int act_err(int i);
        if (i == 0) return int'(er0);
        if (i == 1) return int'(er1);
        return int'(er2);
    endfunction

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d at %0t: got %0h, expected %0h", name, inst, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_run[i] = 0; m_drop[i] = 0; m_lc[i] = 0;
            m_pulse[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        m_pulse[i] = 0;
        if (clr) begin
            m_st[i] = 0; m_run[i] = 0; m_drop[i] = 0;
        end else if (m_ill[i]) begin
            m_st[i] = 0; m_run[i] = 0; m_drop[i] = 0; m_err[i] = 1;
        end else if (en) begin
            case (m_st[i])
                0: m_st[i] = 1;
                1: if (data_in) begin m_st[i] = 2; m_run[i] = 1; end
                2: begin
                    if (!data_in) begin
                        m_st[i] = 1; m_run[i] = 0;
                    end else if (m_run[i] + 1 == P_RL[i]) begin
                        m_st[i] = 3; m_run[i] = 0; m_drop[i] = 0; m_pulse[i] = 1;
                        if (m_lc[i] < P_MAX[i]) m_lc[i]++;
                    end else begin
                        m_run[i]++;
                    end
                end
                default: begin
                    if (data_in) m_drop[i] = 0;
                    else if (m_drop[i] + 1 == P_DL[i]) begin m_st[i] = 1; m_drop[i] = 0; end
                    else m_drop[i]++;
                end
            endcase
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 3; i++) begin
            if (!skip[i]) begin
                chk("estados",    i, act_es(i),  enc_code(P_ENC[i], m_st[i]));
                chk("data_out",   i, act_do(i),  dout(m_st[i]));
                chk("lock_pulse", i, act_lp(i),  int'(m_pulse[i] && en));
                chk("lock_count", i, act_lc(i),  m_lc[i]);
                chk("err",        i, act_err(i), int'(m_err[i]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        compare();
    endtask

    task automatic drive(input bit d);
        data_in = d;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin m_ill[i] = 0; skip[i] = 0; end
        reset_n = 1'b1; en = 1'b0; clr = 1'b0; data_in = 1'b0;
        #1 reset_n = 1'b0;
        model_reset();
        #2;
        compare();
        chk("lit_reset_es2", 2, int'(es2), 4'b0001);
        chk("lit_reset_do0", 0, int'(do0), 2'b01);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // INIT -> WAIT
        en = 1'b1;
        drive(0);
        chk("lit_wait_es0", 0, int'(es0), 2'b01);
        chk("lit_wait_es1", 1, int'(es1), 2'b01);
        chk("lit_wait_es2", 2, int'(es2), 4'b0010);
        chk("lit_wait_do0", 0, int'(do0), 2'b10);

        // Default lock on u0, u1 still running
        drive(1);
        chk("lit_run_do0", 0, int'(do0), 2'b11);
        drive(1);
        chk("lit_lock_do0", 0, int'(do0), 2'b00);
        chk("lit_lock_lp0", 0, int'(lp0), 1);
        chk("lit_lock_lc0", 0, int'(lc0), 1);
        chk("lit_lock_es2", 2, int'(es2), 4'b1000);
        chk("lit_run_do1",  1, int'(do1), 2'b11);
        drive(0);
        chk("lit_drop_do0", 0, int'(do0), 2'b10);
        chk("lit_drop_lp0", 0, int'(lp0), 0);

        // Broken run on u1 (RUN_LEN=4)
        drive(1); drive(1); drive(1); drive(0);
        chk("lit_broken_do1", 1, int'(do1), 2'b10);
        drive(1); drive(1); drive(1);
        chk("lit_prelock_lc1", 1, int'(lc1), 0);
        drive(1);
        chk("lit_lock_lp1", 1, int'(lp1), 1);
        chk("lit_lock_lc1", 1, int'(lc1), 1);

        // Drop filter on u1 (DROP_LEN=3)
        drive(0); drive(0); drive(1); drive(0); drive(0);
        chk("lit_hold_do1", 1, int'(do1), 2'b00);
        drive(0);
        chk("lit_exit_do1", 1, int'(do1), 2'b10);

        // Enable freeze mid-RUN
        drive(1);
        en = 1'b0;
        for (int k = 0; k < 5; k++) drive(1'($urandom_range(0, 1)));
        chk("lit_freeze_do1", 1, int'(do1), 2'b11);
        chk("lit_freeze_lp0", 0, int'(lp0), 0);
        en = 1'b1;

        // Clear from LOCK keeps lock_count
        drive(1); drive(1); drive(1);
        chk("lit_prclr_do1", 1, int'(do1), 2'b00);
        clr = 1'b1;
        drive(1);
        clr = 1'b0;
        chk("lit_clr_do1", 1, int'(do1), 2'b01);
        chk("lit_clr_lc1", 1, int'(lc1), 2);

        // Saturation on u2 (CNT_W=2)
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 5; k++) drive(1);
            for (int k = 0; k < 4; k++) drive(0);
        end
        chk("lit_sat_lc2", 2, int'(lc2), 3);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            en      = ($urandom_range(0, 9) != 0);
            clr     = ($urandom_range(0, 31) == 0);
            data_in = ($urandom_range(0, 9) < 6);
            tick();
        end
        clr = 1'b0;

        // Illegal one-hot code on u2, recovered with en=0
        en = 1'b0;
        force dut2.r_state = 4'b0110;
        #1;
        chk("lit_ill_do2", 2, int'(do2), 2'b00);
        m_ill[2] = 1; skip[2] = 1;
        tick();
        chk("lit_ill_err2", 2, int'(er2), 1);
        release dut2.r_state;
        m_ill[2] = 0; skip[2] = 0;
        tick();
        chk("lit_rec_es2", 2, int'(es2), 4'b0001);
        chk("lit_rec_err2", 2, int'(er2), 1);
        en = 1'b1;
        for (int k = 0; k < 20; k++) drive(1'($urandom_range(0, 1)));

        // Asynchronous reset mid-run, between clock edges
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        compare();
        chk("lit_areset_err2", 2, int'(er2), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(0);
        chk("lit_rel_es1", 1, int'(es1), 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
